// File: rtl/mem_io_scheduler_pkg.sv
// Shared types and constants for the fetch/load-store RAM and IO scheduler.
package mem_io_pkg;

    localparam logic [21:0] IO_HI    = 22'h3FFFFF;
    localparam int          IO_OFF_W = 10;
    localparam int          WORD_LSB = 2;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_RESP_F     = 2'd1,
        S_RESP_D_RAM = 2'd2,
        S_RESP_D_IO  = 2'd3
    } sched_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_io_scheduler_if.sv
// Core, RAM and IO side signals of the scheduler; slave = scheduler, master = environment.
interface mem_io_if import mem_io_pkg::*; #(
    parameter int AW = 14
);
    logic                i_req_unused_guard;
    logic                if_req;
    logic [31:0]         if_addr;
    logic [31:0]         if_rdata;
    logic                if_valid;
    logic                d_req;
    logic                d_we;
    logic [3:0]          d_be;
    logic [31:0]         d_addr;
    logic [31:0]         d_wdata;
    logic [31:0]         d_rdata;
    logic                d_valid;
    logic                ram_en;
    logic [3:0]          ram_we;
    logic [AW-1:0]       ram_addr;
    logic [31:0]         ram_wdata;
    logic [31:0]         ram_rdata;
    logic                io_read;
    logic                io_write;
    logic [IO_OFF_W-1:0] io_addr;
    logic [31:0]         io_wdata;
    logic [31:0]         io_rdata;
    logic                stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata, io_rdata,
        output if_rdata, if_valid, d_rdata, d_valid, ram_en, ram_we, ram_addr, ram_wdata,
               io_read, io_write, io_addr, io_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata, io_rdata,
        input  if_rdata, if_valid, d_rdata, d_valid, ram_en, ram_we, ram_addr, ram_wdata,
               io_read, io_write, io_addr, io_wdata, stall
    );

endinterface

// File: rtl/mem_io_scheduler_addr_decode.sv
// Splits a byte address into IO-space select, RAM word address and IO offset.
module mem_io_addr_decode import mem_io_pkg::*; #(
    parameter int          AW    = 14,
    parameter logic [21:0] IO_HI = mem_io_pkg::IO_HI
) (
    input  logic [31:0]         addr,
    output logic                is_io,
    output logic [AW-1:0]       ram_addr,
    output logic [IO_OFF_W-1:0] io_off
);

    assign is_io    = (addr[31:IO_OFF_W] == IO_HI);
    // Upper bits beyond the RAM depth are dropped, so accesses wrap.
    assign ram_addr = addr[AW+WORD_LSB-1:WORD_LSB];
    assign io_off   = addr[IO_OFF_W-1:0];

endmodule

// File: rtl/mem_io_scheduler.sv
// Arbitrates the single-port RAM between fetch and load/store, bridges IO space.
// Optional performance counters enabled by MEM_IO_SCHED_PERF_EN.
//
// state        | meaning
// S_IDLE       | grant cycle: data first, then fetch; strobes driven combinationally
// S_RESP_F     | fetch read in flight, capture instruction, pulse if_valid next
// S_RESP_D_RAM | data RAM access in flight, capture load data, pulse d_valid next
// S_RESP_D_IO  | IO access done in grant cycle, pulse d_valid next
module mem_io_scheduler import mem_io_pkg::*; #(
    parameter int          AW    = 14,
    parameter logic [21:0] IO_HI = mem_io_pkg::IO_HI
) (
    input  logic        clk,
    input  logic        rst,
    mem_io_if.slave     bus
`ifdef MEM_IO_SCHED_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] fetch_cnt,
    output logic [31:0] data_cnt
`endif
);

    sched_state_t        state, state_nxt;
    logic                d_is_io;
    logic [AW-1:0]       d_ram_addr;
    logic [AW-1:0]       f_ram_addr;
    logic [IO_OFF_W-1:0] d_io_off;
    logic                unused_f_is_io;
    logic [IO_OFF_W-1:0] unused_f_io_off;
    logic                d_pend, f_pend;
    logic                grant_d_ram, grant_d_io, grant_f;
    logic                we_q;

    mem_io_addr_decode #(.AW(AW), .IO_HI(IO_HI)) u_dec_d (
        .addr     (bus.d_addr),
        .is_io    (d_is_io),
        .ram_addr (d_ram_addr),
        .io_off   (d_io_off)
    );

    mem_io_addr_decode #(.AW(AW), .IO_HI(IO_HI)) u_dec_f (
        .addr     (bus.if_addr),
        .is_io    (unused_f_is_io),
        .ram_addr (f_ram_addr),
        .io_off   (unused_f_io_off)
    );

    // A request is still held during its own valid cycle; it must not be granted again.
    assign d_pend = bus.d_req  & ~bus.d_valid;
    assign f_pend = bus.if_req & ~bus.if_valid;

    always_comb begin
        state_nxt   = state;
        grant_d_ram = 1'b0;
        grant_d_io  = 1'b0;
        grant_f     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rst) begin
                    if (d_pend) begin
                        if (d_is_io) begin
                            grant_d_io = 1'b1;
                            state_nxt  = S_RESP_D_IO;
                        end else begin
                            grant_d_ram = 1'b1;
                            state_nxt   = S_RESP_D_RAM;
                        end
                    end else if (f_pend) begin
                        grant_f   = 1'b1;
                        state_nxt = S_RESP_F;
                    end
                end
            end
            S_RESP_F, S_RESP_D_RAM, S_RESP_D_IO: state_nxt = S_IDLE;
            default:                             state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ram_en    = grant_d_ram | grant_f;
        bus.ram_we    = (grant_d_ram & bus.d_we) ? bus.d_be : 4'b0000;
        bus.ram_addr  = grant_d_ram ? d_ram_addr : f_ram_addr;
        bus.ram_wdata = bus.d_wdata;
        bus.io_read   = grant_d_io & ~bus.d_we;
        bus.io_write  = grant_d_io &  bus.d_we;
        bus.io_addr   = d_io_off;
        bus.io_wdata  = bus.d_wdata;
        bus.stall     = (bus.if_req & ~bus.if_valid) | (bus.d_req & ~bus.d_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            we_q         <= 1'b0;
            bus.if_valid <= 1'b0;
            bus.d_valid  <= 1'b0;
            bus.if_rdata <= 32'd0;
            bus.d_rdata  <= 32'd0;
        end else begin
            state        <= state_nxt;
            bus.if_valid <= (state == S_RESP_F);
            bus.d_valid  <= (state == S_RESP_D_RAM) | (state == S_RESP_D_IO);
            if (grant_d_ram | grant_d_io)
                we_q <= bus.d_we;
            // IO read data is only valid while io_read is high, so capture it in the grant cycle.
            if (grant_d_io & ~bus.d_we)
                bus.d_rdata <= bus.io_rdata;
            if ((state == S_RESP_D_RAM) && !we_q)
                bus.d_rdata <= bus.ram_rdata;
            if (state == S_RESP_F)
                bus.if_rdata <= bus.ram_rdata;
        end
    end

`ifdef MEM_IO_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            fetch_cnt    <= 32'd0;
            data_cnt     <= 32'd0;
        end else begin
            if (bus.stall)    stall_cycles <= sat_inc(stall_cycles);
            if (bus.if_valid) fetch_cnt    <= sat_inc(fetch_cnt);
            if (bus.d_valid)  data_cnt     <= sat_inc(data_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_mem_io_scheduler.sv
// Directed self-checking bench for mem_io_scheduler with a behavioural RAM and IO source.
module tb_mem_io_scheduler;
    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] mem [0:(1<<AW)-1];

    mem_io_if #(.AW(AW)) bus ();

`ifdef MEM_IO_SCHED_PERF_EN
    logic [31:0] stall_cycles, fetch_cnt, data_cnt;
    mem_io_scheduler #(.AW(AW)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave),
        .stall_cycles (stall_cycles), .fetch_cnt (fetch_cnt), .data_cnt (data_cnt)
    );
`else
    mem_io_scheduler #(.AW(AW)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );
`endif

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            mem[2]  <= 32'h1122_3344;
            mem[4]  <= 32'h0050_0093;
            mem[16] <= 32'hCAFE_F00D;
        end else if (bus.ram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        preload = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.if_valid, bus.d_valid, bus.ram_en, bus.io_read, bus.io_write, bus.ram_we} !== 9'd0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 0", {bus.if_valid, bus.d_valid, bus.ram_en, bus.io_read, bus.io_write, bus.ram_we});
        end
        checks++;
        if ({bus.if_rdata, bus.d_rdata} !== 64'd0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", {bus.if_rdata, bus.d_rdata});
        end
        preload = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        #1;
        checks++;
        if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.stall} !== {1'b1, 4'b0, 14'd4, 1'b1}) begin
            errors++;
            $display("FAIL fetch_grant: got en=%b we=%b addr=%0d stall=%b expected en=1 we=0 addr=4 stall=1", bus.ram_en, bus.ram_we, bus.ram_addr, bus.stall);
        end
        tick();
        checks++;
        if ({bus.if_valid, bus.ram_en, bus.stall} !== 3'b001) begin
            errors++;
            $display("FAIL fetch_wait: got valid/en/stall=%b expected 001", {bus.if_valid, bus.ram_en, bus.stall});
        end
        tick();
        checks++;
        if ({bus.if_valid, bus.if_rdata, bus.stall, bus.ram_en} !== {1'b1, 32'h0050_0093, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fetch_resp: got valid=%b data=%h stall=%b en=%b expected 1 00500093 0 0", bus.if_valid, bus.if_rdata, bus.stall, bus.ram_en);
        end
        bus.if_req = 1'b0;
        tick();
        checks++;
        if (bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_pulse: got if_valid=%b expected 0", bus.if_valid);
        end
    endtask

    task automatic test_collision();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        #1;
        checks++;
        if ({bus.ram_en, bus.ram_we, bus.ram_addr} !== {1'b1, 4'b0, 14'd16}) begin
            errors++;
            $display("FAIL coll_data_first: got en=%b we=%b addr=%0d expected 1 0 16", bus.ram_en, bus.ram_we, bus.ram_addr);
        end
        tick();
        checks++;
        if ({bus.ram_en, bus.d_valid, bus.if_valid, bus.stall} !== 4'b0001) begin
            errors++;
            $display("FAIL coll_resp_d: got en/dv/iv/stall=%b expected 0001", {bus.ram_en, bus.d_valid, bus.if_valid, bus.stall});
        end
        tick();
        checks++;
        if ({bus.d_valid, bus.d_rdata, bus.if_valid} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
            errors++;
            $display("FAIL coll_d_done: got dv=%b data=%h iv=%b expected 1 cafef00d 0", bus.d_valid, bus.d_rdata, bus.if_valid);
        end
        checks++;
        if ({bus.ram_en, bus.ram_addr} !== {1'b1, 14'd4}) begin
            errors++;
            $display("FAIL coll_fetch_grant: got en=%b addr=%0d expected 1 4", bus.ram_en, bus.ram_addr);
        end
        bus.d_req = 1'b0;
        tick();
        checks++;
        if ({bus.d_valid, bus.if_valid, bus.stall} !== 3'b001) begin
            errors++;
            $display("FAIL coll_fetch_wait: got dv/iv/stall=%b expected 001", {bus.d_valid, bus.if_valid, bus.stall});
        end
        tick();
        checks++;
        if ({bus.if_valid, bus.if_rdata} !== {1'b1, 32'h0050_0093}) begin
            errors++;
            $display("FAIL coll_fetch_done: got iv=%b data=%h expected 1 00500093", bus.if_valid, bus.if_rdata);
        end
        bus.if_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
        bus.d_addr = 32'h8; bus.d_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.io_write} !== {1'b1, 4'b0011, 14'd2, 32'hDEAD_BEEF, 1'b0}) begin
            errors++;
            $display("FAIL store_grant: got en=%b we=%b addr=%0d wdata=%h expected 1 0011 2 deadbeef", bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        tick();
        tick();
        checks++;
        if (bus.d_valid !== 1'b1) begin
            errors++;
            $display("FAIL store_valid: got d_valid=%b expected 1", bus.d_valid);
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        tick();
        bus.d_req = 1'b1; bus.d_addr = 32'h8;
        tick();
        tick();
        checks++;
        if ({bus.d_valid, bus.d_rdata} !== {1'b1, 32'h1122_BEEF}) begin
            errors++;
            $display("FAIL store_readback: got dv=%b data=%h expected 1 1122beef", bus.d_valid, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_io();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'hFFFF_FC10; bus.io_rdata = 32'h5A;
        #1;
        checks++;
        if ({bus.io_read, bus.io_write, bus.io_addr, bus.ram_en} !== {1'b1, 1'b0, 10'h010, 1'b0}) begin
            errors++;
            $display("FAIL io_load_grant: got rd=%b wr=%b addr=%h en=%b expected 1 0 010 0", bus.io_read, bus.io_write, bus.io_addr, bus.ram_en);
        end
        tick();
        bus.io_rdata = 32'hFFFF_0000;
        #1;
        checks++;
        if ({bus.io_read, bus.d_valid} !== 2'b00) begin
            errors++;
            $display("FAIL io_load_resp: got rd/dv=%b expected 00", {bus.io_read, bus.d_valid});
        end
        tick();
        checks++;
        if ({bus.d_valid, bus.d_rdata} !== {1'b1, 32'h5A}) begin
            errors++;
            $display("FAIL io_load_done: got dv=%b data=%h expected 1 0000005a", bus.d_valid, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_wdata = 32'h1234_5678;
        #1;
        checks++;
        if ({bus.io_read, bus.io_write, bus.io_addr, bus.io_wdata, bus.ram_en} !== {1'b0, 1'b1, 10'h010, 32'h1234_5678, 1'b0}) begin
            errors++;
            $display("FAIL io_store_grant: got rd=%b wr=%b addr=%h wdata=%h en=%b expected 0 1 010 12345678 0", bus.io_read, bus.io_write, bus.io_addr, bus.io_wdata, bus.ram_en);
        end
        tick();
        tick();
        checks++;
        if ({bus.d_valid, bus.d_rdata} !== {1'b1, 32'h5A}) begin
            errors++;
            $display("FAIL io_store_done: got dv=%b data=%h expected 1 0000005a", bus.d_valid, bus.d_rdata);
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        tick();
    endtask

    task automatic test_zero_be_and_wrap();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0000; bus.d_addr = 32'h8; bus.d_wdata = 32'h0;
        #1;
        checks++;
        if ({bus.ram_en, bus.ram_we} !== {1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL zero_be_grant: got en=%b we=%b expected 1 0000", bus.ram_en, bus.ram_we);
        end
        tick();
        tick();
        checks++;
        if (bus.d_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_be_valid: got d_valid=%b expected 1", bus.d_valid);
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        tick();
        bus.d_req = 1'b1; bus.d_addr = 32'h0001_000B;
        #1;
        checks++;
        if ({bus.ram_en, bus.ram_addr} !== {1'b1, 14'd2}) begin
            errors++;
            $display("FAIL wrap_addr: got en=%b addr=%0d expected 1 2", bus.ram_en, bus.ram_addr);
        end
        tick();
        tick();
        checks++;
        if ({bus.d_valid, bus.d_rdata} !== {1'b1, 32'h1122_BEEF}) begin
            errors++;
            $display("FAIL wrap_data: got dv=%b data=%h expected 1 1122beef", bus.d_valid, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.ram_en, bus.ram_we, bus.io_read, bus.io_write, bus.d_valid, bus.d_rdata} !== 40'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got en=%b we=%b rd=%b wr=%b dv=%b data=%h expected all 0", bus.ram_en, bus.ram_we, bus.io_read, bus.io_write, bus.d_valid, bus.d_rdata);
        end
        tick();
        checks++;
        if ({bus.ram_en, bus.d_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_hold: got en/dv=%b expected 00", {bus.ram_en, bus.d_valid});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.ram_en, bus.ram_addr} !== {1'b1, 14'd16}) begin
            errors++;
            $display("FAIL rst_reissue_grant: got en=%b addr=%0d expected 1 16", bus.ram_en, bus.ram_addr);
        end
        tick();
        checks++;
        if (bus.d_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_reissue_wait: got d_valid=%b expected 0", bus.d_valid);
        end
        tick();
        checks++;
        if ({bus.d_valid, bus.d_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL rst_reissue_done: got dv=%b data=%h expected 1 cafef00d", bus.d_valid, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        tick();
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        bus.io_rdata = 32'h0;
        rst = 1'b1;
        preload = 1'b1;
        test_reset();
        test_fetch();
        test_collision();
        test_store();
        test_io();
        test_zero_be_and_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
